// File: rtl/mem_write_arbiter_pkg.sv
// Shared types and the round-robin pick rule for the memory write arbiter.
// Imported by the arbiter top and the rr_arbiter sub-module.
package mem_write_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam int STAT_CNT_WIDTH = 32;

    // Scans last+1, last+2, ... modulo n; lowest distance from last wins.
    function automatic logic [2:0] rr_next(
        input logic [7:0] req,
        input logic [2:0] last,
        input int         n
    );
        logic [2:0] win;
        int         idx;
        win = last;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx[2:0]]) win = idx[2:0];
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Requester-side and engine-side bus of the memory write arbiter.
// slave = arbiter view, master = surrounding producers and engine.
interface mem_write_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 64
);
    localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_error;
    logic [NUM_REQ-1:0]            fifo_rd_en;
    logic [NUM_REQ*DATA_WIDTH-1:0] fifo_rd_data;
    logic                          eng_start;
    logic [ADDR_WIDTH-1:0]         eng_addr;
    logic [LEN_WIDTH-1:0]          eng_len;
    logic                          eng_busy;
    logic                          eng_done;
    logic                          eng_error;
    logic                          eng_rd_en;
    logic [DATA_WIDTH-1:0]         eng_rd_data;
    logic                          grant_active;
    logic [IDX_WIDTH-1:0]          grant_idx;

    modport slave (
        input  req_valid, req_addr, req_len, fifo_rd_data,
        input  eng_busy, eng_done, eng_error, eng_rd_en,
        output req_ready, req_done, req_error, fifo_rd_en,
        output eng_start, eng_addr, eng_len, eng_rd_data,
        output grant_active, grant_idx
    );

    modport master (
        output req_valid, req_addr, req_len, fifo_rd_data,
        output eng_busy, eng_done, eng_error, eng_rd_en,
        input  req_ready, req_done, req_error, fifo_rd_en,
        input  eng_start, eng_addr, eng_len, eng_rd_data,
        input  grant_active, grant_idx
    );

endinterface

// File: rtl/mem_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: request vector and last grant in,
// winning index and any-request flag out.
module rr_arbiter
    import mem_write_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] last_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 any_o
);

    logic [7:0] req_ext;
    logic [2:0] last_ext;
    logic [2:0] win;

    assign req_ext  = 8'(req_i);
    assign last_ext = 3'(last_i);
    assign win      = rr_next(req_ext, last_ext, NUM_REQ);
    assign idx_o    = IDX_WIDTH'(win);
    assign any_o    = |req_i;

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin sharing of one FIFO-to-AXI write engine between requesters.
// Define MEM_WRITE_ARB_STATS_EN for per-requester done/error counters.
module mem_write_arbiter
    import mem_write_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 64,
    localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic clock,
    input  logic resetn,
    mem_write_arb_if.slave bus
`ifdef MEM_WRITE_ARB_STATS_EN
    ,
    input  logic [IDX_WIDTH-1:0]      stat_sel,
    input  logic                      stat_clear,
    output logic [STAT_CNT_WIDTH-1:0] stat_done_cnt,
    output logic [STAT_CNT_WIDTH-1:0] stat_err_cnt
`endif
);

    state_t                state_q;
    logic [IDX_WIDTH-1:0]  last_q;
    logic [IDX_WIDTH-1:0]  grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [NUM_REQ-1:0]    ready_q;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    err_q;
    logic                  start_q;
    logic                  active_q;

    logic [IDX_WIDTH-1:0]  win;
    logic                  any_req;
    logic                  unused_busy;

    // Busy is informational only; completion is taken from eng_done alone.
    assign unused_busy = bus.eng_busy;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr (
        .req_i  (bus.req_valid),
        .last_i (last_q),
        .idx_o  (win),
        .any_o  (any_req)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            last_q   <= IDX_WIDTH'(NUM_REQ - 1);
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            ready_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            ready_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q  <= win;
                        last_q   <= win;
                        addr_q   <= bus.req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                        len_q    <= bus.req_len[int'(win)*LEN_WIDTH +: LEN_WIDTH];
                        ready_q  <= NUM_REQ'(1) << win;
                        start_q  <= 1'b1;
                        active_q <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.eng_done) begin
                        done_q   <= NUM_REQ'(1) << grant_q;
                        err_q    <= bus.eng_error ? (NUM_REQ'(1) << grant_q) : '0;
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.fifo_rd_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.fifo_rd_en[i] = bus.eng_rd_en & active_q & (grant_q == IDX_WIDTH'(i));
        end
    end

    assign bus.eng_rd_data  = bus.fifo_rd_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.req_ready    = ready_q;
    assign bus.req_done     = done_q;
    assign bus.req_error    = err_q;
    assign bus.eng_start    = start_q;
    assign bus.eng_addr     = addr_q;
    assign bus.eng_len      = len_q;
    assign bus.grant_active = active_q;
    assign bus.grant_idx    = grant_q;

`ifdef MEM_WRITE_ARB_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] done_cnt_q [NUM_REQ];
    logic [STAT_CNT_WIDTH-1:0] err_cnt_q  [NUM_REQ];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                done_cnt_q[i] <= '0;
                err_cnt_q[i]  <= '0;
            end
        end else if (stat_clear) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                done_cnt_q[i] <= '0;
                err_cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_q[i] && done_cnt_q[i] != '1)
                    done_cnt_q[i] <= done_cnt_q[i] + 1'b1;
                if (done_q[i] && err_q[i] && err_cnt_q[i] != '1)
                    err_cnt_q[i] <= err_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_done_cnt = '0;
        stat_err_cnt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == IDX_WIDTH'(i)) begin
                stat_done_cnt = done_cnt_q[i];
                stat_err_cnt  = err_cnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Randomized self-checking bench for mem_write_arbiter against a
// transaction-level round-robin model (stats checked when enabled).
module tb_mem_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int DW = 64;
    localparam int IW = 2;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    mem_write_arb_if #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)
    ) bus ();

`ifdef MEM_WRITE_ARB_STATS_EN
    logic [IW-1:0] stat_sel;
    logic          stat_clear;
    logic [31:0]   stat_done_cnt;
    logic [31:0]   stat_err_cnt;
`endif

    mem_write_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
`ifdef MEM_WRITE_ARB_STATS_EN
        ,
        .stat_sel      (stat_sel),
        .stat_clear    (stat_clear),
        .stat_done_cnt (stat_done_cnt),
        .stat_err_cnt  (stat_err_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference rule: first valid requester after the last grant, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_fifo();
        for (int i = 0; i < N; i++)
            bus.fifo_rd_data[i*DW +: DW] = {$urandom, $urandom};
    endtask

    int            last_m;
    int            w;
    int            prev_w;
    logic [N-1:0]  held;
    logic [N-1:0]  fresh;
    logic [N-1:0]  mask;
    logic          err;
    logic [AW-1:0] a_exp;
    logic [LW-1:0] l_exp;
    int            done_cnt [N];
    int            err_cnt  [N];

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"},  64'(bus.req_ready), 64'(0));
        chk({tag, "_done"},   64'(bus.req_done), 64'(0));
        chk({tag, "_err"},    64'(bus.req_error), 64'(0));
        chk({tag, "_start"},  64'(bus.eng_start), 64'(0));
        chk({tag, "_active"}, 64'(bus.grant_active), 64'(0));
        chk({tag, "_gidx"},   64'(bus.grant_idx), 64'(0));
        chk({tag, "_addr"},   64'(bus.eng_addr), 64'(0));
        chk({tag, "_len"},    64'(bus.eng_len), 64'(0));
        chk({tag, "_rden"},   64'(bus.fifo_rd_en), 64'(0));
    endtask

    initial begin
        bus.req_valid    = '0;
        bus.req_addr     = '0;
        bus.req_len      = '0;
        bus.fifo_rd_data = '0;
        bus.eng_busy     = 1'b0;
        bus.eng_done     = 1'b0;
        bus.eng_error    = 1'b0;
        bus.eng_rd_en    = 1'b0;
`ifdef MEM_WRITE_ARB_STATS_EN
        stat_sel   = '0;
        stat_clear = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            done_cnt[i] = 0;
            err_cnt[i]  = 0;
        end
        #12;
        check_idle_outputs("reset");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        last_m = N - 1;
        held   = '0;
        prev_w = -1;

        for (int r = 0; r < 48; r++) begin
            if (r == 0) fresh = 4'b0001;
            else if (r == 1 || r == 5) fresh = 4'b1111;
            else if (r == 32) fresh = 4'b1000;
            else fresh = 4'($urandom);
            fresh = fresh & ~held;
            for (int i = 0; i < N; i++) begin
                if (fresh[i]) begin
                    bus.req_addr[i*AW +: AW] = $urandom;
                    bus.req_len[i*LW +: LW]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
                end
            end
            if (r == 0) begin
                bus.req_addr[0 +: AW] = 32'h1000;
                bus.req_len[0 +: LW]  = 16'd64;
            end
            mask = held | fresh;

            if (mask == '0) begin
                bus.eng_done = 1'b1;
                tick();
                bus.eng_done = 1'b0;
                chk("spur_done",   64'(bus.req_done), 64'(0));
                chk("spur_ready",  64'(bus.req_ready), 64'(0));
                chk("spur_active", 64'(bus.grant_active), 64'(0));
                continue;
            end

`ifdef MEM_WRITE_ARB_STATS_EN
            if (r == 20) begin
                stat_clear = 1'b1;
                for (int i = 0; i < N; i++) begin
                    done_cnt[i] = 0;
                    err_cnt[i]  = 0;
                end
            end
`endif
            bus.req_valid = mask;
            w     = pick(mask, last_m);
            a_exp = bus.req_addr[w*AW +: AW];
            l_exp = bus.req_len[w*LW +: LW];
            tick();
            chk("acc_ready",  64'(bus.req_ready), 64'(N'(1) << w));
            chk("acc_start",  64'(bus.eng_start), 64'(1));
            chk("acc_active", 64'(bus.grant_active), 64'(1));
            chk("acc_gidx",   64'(bus.grant_idx), 64'(w));
            chk("acc_addr",   64'(bus.eng_addr), 64'(a_exp));
            chk("acc_len",    64'(bus.eng_len), 64'(l_exp));
            if (r == 31) chk("rst_rr_first", 64'(w), 64'(0));
`ifdef MEM_WRITE_ARB_STATS_EN
            stat_clear = 1'b0;
            if (prev_w >= 0) begin
                stat_sel = IW'(prev_w);
                #1;
                chk("stat_done", 64'(stat_done_cnt), 64'(done_cnt[prev_w]));
                chk("stat_err",  64'(stat_err_cnt), 64'(err_cnt[prev_w]));
            end
`endif
            held = mask & ~(N'(1) << w);
            bus.req_valid = held;
            last_m = w;

            if (r == 30) begin
                bus.eng_rd_en = 1'b1;
                #2;
                resetn = 1'b0;
                #1;
                check_idle_outputs("midrst");
                bus.eng_rd_en = 1'b0;
                bus.req_valid = '0;
                @(posedge clock);
                #1;
                resetn = 1'b1;
                last_m = N - 1;
                held   = 4'b1111;
                prev_w = -1;
                for (int i = 0; i < N; i++) begin
                    done_cnt[i] = 0;
                    err_cnt[i]  = 0;
                end
`ifdef MEM_WRITE_ARB_STATS_EN
                for (int i = 0; i < N; i++) begin
                    stat_sel = IW'(i);
                    #1;
                    chk("rst_stat_done", 64'(stat_done_cnt), 64'(0));
                    chk("rst_stat_err",  64'(stat_err_cnt), 64'(0));
                end
`endif
                continue;
            end

            tick();
            chk("one_ready", 64'(bus.req_ready), 64'(0));
            chk("one_start", 64'(bus.eng_start), 64'(0));

            for (int c = 0; c < $urandom_range(1, 5); c++) begin
                bus.eng_rd_en = 1'($urandom);
                bus.eng_busy  = 1'($urandom);
                drive_fifo();
                #1;
                chk("steer_en", 64'(bus.fifo_rd_en),
                    bus.eng_rd_en ? 64'(N'(1) << w) : 64'(0));
                chk("steer_data", bus.eng_rd_data, bus.fifo_rd_data[w*DW +: DW]);
                chk("wait_active", 64'(bus.grant_active), 64'(1));
                tick();
            end

            err           = 1'($urandom);
            bus.eng_done  = 1'b1;
            bus.eng_error = err;
            bus.eng_busy  = 1'b0;
            bus.eng_rd_en = 1'b0;
            tick();
            bus.eng_done  = 1'b0;
            bus.eng_error = 1'b0;
            chk("done_vec",    64'(bus.req_done), 64'(N'(1) << w));
            chk("done_err",    64'(bus.req_error), err ? 64'(N'(1) << w) : 64'(0));
            chk("done_active", 64'(bus.grant_active), 64'(0));
            chk("done_noacc",  64'(bus.req_ready), 64'(0));
            chk("done_gidx",   64'(bus.grant_idx), 64'(w));
            bus.eng_rd_en = 1'b1;
            #1;
            chk("post_rden", 64'(bus.fifo_rd_en), 64'(0));
            bus.eng_rd_en = 1'b0;
            done_cnt[w]++;
            if (err) err_cnt[w]++;
            prev_w = w;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_write_arbiter.md
Name: mem_write_arbiter

Overview:
- Shares one FIFO-to-AXI write engine between NUM_REQ requesters, round-robin.
- Each requester issues a write command (addr, len) and owns a source FIFO.
- The arbiter forwards the granted command as a start pulse, steers the engine's FIFO reads to the granted requester, and routes done/error back.
- Sits between the packet/DMA producers and the single write engine on the memory-write path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 16, byte length width.
- DATA_WIDTH, 64, FIFO/AXI data width.
- IDX_WIDTH, $clog2(NUM_REQ) (localparam, min 1), grant index width.

Ports:
- clock  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid; held until req_ready.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed command addresses.
- req_len  in  NUM_REQ*LEN_WIDTH  packed command lengths.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_error  out  NUM_REQ  error flag, valid with req_done.
- fifo_rd_en  out  NUM_REQ  read enables to requester FIFOs.
- fifo_rd_data  in  NUM_REQ*DATA_WIDTH  requester FIFO read data.
- eng_start  out  1  start pulse to engine.
- eng_addr  out  ADDR_WIDTH  registered command address.
- eng_len  out  LEN_WIDTH  registered command length.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine completion pulse.
- eng_error  in  1  engine error, valid with eng_done.
- eng_rd_en  in  1  engine FIFO read enable.
- eng_rd_data  out  DATA_WIDTH  muxed FIFO data to engine.
- grant_active  out  1  high from accept through done.
- grant_idx  out  IDX_WIDTH  current or last grant index.

Behaviour:
- Reset values: all outputs 0; state ST_IDLE; round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- Arbitration: in ST_IDLE with any req_valid, the winner is the first set bit searching last+1, last+2, ... with modulo-NUM_REQ wrap.
- Accept, same edge: register grant_idx and eng_addr/eng_len from the winner's slice; pulse req_ready[winner]; pulse eng_start; set grant_active; update last to the winner; go to ST_WAIT.
- Latency: req_valid sampled high at edge N gives req_ready and eng_start high during cycle N+1.
- ST_WAIT: on eng_done, pulse req_done[grant_idx] with req_error[grant_idx] = eng_error; clear grant_active; go to ST_IDLE.
- The next arbitration happens earliest on the edge after req_done. Back-to-back commands have a one-idle-cycle gap.
- eng_done is accepted regardless of eng_busy. Example: a zero-length command makes the engine report done+error without ever raising busy.
- eng_done seen in ST_IDLE is ignored (spurious).
- Data steering (combinational):
  - fifo_rd_en[i] = eng_rd_en & grant_active & (grant_idx == i).
  - eng_rd_data = fifo_rd_data slice [grant_idx].
  - When not grant_active, all fifo_rd_en are 0.
- Request lines deasserting before acceptance are permitted; that requester is simply not considered.
- Commands are never pre-empted. Only one outstanding command at a time.
- Reset mid-transfer: asynchronous return to reset values. No req_done is issued for the aborted command. The engine must share the same reset.

Optional Feature:
MEM_WRITE_ARB_STATS_EN
- Defined:
  - Adds ports stat_sel (in, IDX_WIDTH), stat_done_cnt (out, 32) and stat_err_cnt (out, 32).
  - Per-requester saturating counters increment on req_done, and on req_done&req_error respectively.
  - Counters reset to 0 and are read combinationally via stat_sel.
  - stat_clear (in, 1) zeroes all counters; it takes priority over increments in the same cycle.
- Undefined: no ports, no counters. Behaviour is otherwise identical.

Decomposition:
- Package mem_write_arb_pkg holds:
  - typedef state_t {ST_IDLE, ST_WAIT}.
  - Function rr_next(req, last) returning the winner index.
  - Constant STAT_CNT_WIDTH = 32.
- One natural sub-module, rr_arbiter: combinational round-robin pick (req vector, last pointer → winner index, any_valid). The top keeps the FSM, registers and muxes.

Test Plan:
- Single request: req_valid=0001, addr=0x1000, len=64 → req_ready[0] and eng_start one cycle later; eng_addr=0x1000, eng_len=64; eng_done → req_done=0001, req_error=0.
- Fairness: req_valid=1111 held → grant order 0,1,2,3,0; each req_ready exactly one cycle; one idle cycle between done and the next start.
- FIFO steering: grant 2, eng_rd_en toggled → only fifo_rd_en[2] pulses; eng_rd_data equals the fifo_rd_data[2] pattern; no rd_en on others before start or after done.
- Zero length: req 1 with len=0, engine returns done+error without busy → req_done[1]=1, req_error[1]=1, back to ST_IDLE.
- Simultaneous events: req 3 asserts in the same cycle as eng_done for grant 0 → no grant that cycle; req 3 granted on the following edge; spurious eng_done in ST_IDLE produces no req_done.
- Reset mid-operation: resetn low during ST_WAIT → all outputs 0 immediately; after release, requester 0 wins a 1111 request; with MEM_WRITE_ARB_STATS_EN, counters read 0.
